// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply-divide unit: op encodings, FSM states
// and default latencies. Decode imports this package too.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101,
    OP_MADD  = 3'b110,
    OP_MSUB  = 3'b111
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;
  localparam int          CNT_W           = 16;

endpackage

// File: rtl/mdu_hilo.sv
// HI/LO multiply-divide unit: results computed at issue, held in pending and
// committed after a counted latency. Define MDU_MADD_EN to enable madd/msub (ops 110/111).
//
// state   | meaning
// ST_IDLE | accepting mult/div/mthi/mtlo, Busy low
// ST_RUN  | op in flight, counter running down to commit, Busy high
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        Busy
);

  // Counter is loaded with N-1 so that commit lands on the N-th edge after issue.
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  state_e            state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic [63:0]       pending;
  op_e               op_dec;
  logic              idle, commit;
  logic              take_arith, take_mthi, take_mtlo;
  logic [63:0]       result;
  logic [CNT_W-1:0]  cnt_load;

  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, b_mag_nz, b_nz;
  logic [31:0] qs_mag, rs_mag, qs, rs, qu, ru;

  assign op_dec = op_e'(op);
  assign idle   = (state == ST_IDLE);
  assign commit = (state == ST_RUN) && (cnt == '0);

  always_comb begin
    prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    prod_u = {32'b0, A} * {32'b0, B};
  end

  // Signed division via magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  always_comb begin
    a_mag    = A[31] ? (~A + 32'd1) : A;
    b_mag    = B[31] ? (~B + 32'd1) : B;
    b_mag_nz = (b_mag == '0) ? 32'd1 : b_mag;
    b_nz     = (B == '0) ? 32'd1 : B;
    qs_mag   = a_mag / b_mag_nz;
    rs_mag   = a_mag % b_mag_nz;
    qs       = (A[31] ^ B[31]) ? (~qs_mag + 32'd1) : qs_mag;
    rs       = A[31] ? (~rs_mag + 32'd1) : rs_mag;
    qu       = A / b_nz;
    ru       = A % b_nz;
  end

  always_comb begin
    result     = {HI, LO};
    cnt_load   = '0;
    take_arith = 1'b0;
    take_mthi  = 1'b0;
    take_mtlo  = 1'b0;
    if (start && idle) begin
      case (op_dec)
        OP_MULT:  begin take_arith = 1'b1; cnt_load = MULT_LOAD; result = prod_s; end
        OP_MULTU: begin take_arith = 1'b1; cnt_load = MULT_LOAD; result = prod_u; end
        OP_DIV: begin
          take_arith = 1'b1;
          cnt_load   = DIV_LOAD;
          if (B != '0) result = {rs, qs};
        end
        OP_DIVU: begin
          take_arith = 1'b1;
          cnt_load   = DIV_LOAD;
          if (B != '0) result = {ru, qu};
        end
        OP_MTHI: take_mthi = 1'b1;
        OP_MTLO: take_mtlo = 1'b1;
`ifdef MDU_MADD_EN
        OP_MADD: begin take_arith = 1'b1; cnt_load = MULT_LOAD; result = {HI, LO} + prod_s; end
        OP_MSUB: begin take_arith = 1'b1; cnt_load = MULT_LOAD; result = {HI, LO} - prod_s; end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (take_arith) state_next = ST_RUN;
      ST_RUN:  if (commit)     state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    Busy = (state == ST_RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      pending <= '0;
      HI      <= '0;
      LO      <= '0;
    end else begin
      if (take_arith) begin
        pending <= result;
        cnt     <= cnt_load;
      end else if (state == ST_RUN && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (commit) begin
        HI <= pending[63:32];
        LO <= pending[31:0];
      end else begin
        if (take_mthi) HI <= A;
        if (take_mtlo) LO <= A;
      end
    end
  end

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: directed cases plus randomized ops against an
// operation-level model using 64-bit integer arithmetic.
module tb_mdu_hilo;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A, B;
  logic [31:0] HI, LO;
  logic        Busy;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] m_hi, m_lo;

  mdu_hilo #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .HI(HI), .LO(LO), .Busy(Busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Architectural effect of one accepted start; cyc=0 means no Busy period.
  function automatic void ref_eval(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] hi, input logic [31:0] lo,
                                   output logic [63:0] res, output int cyc);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    res = {hi, lo};
    cyc = 0;
    case (o)
      3'd0: begin res = sa * sb; cyc = MC; end
      3'd1: begin res = ua * ub; cyc = MC; end
      3'd2: begin
        cyc = DC;
        if (b != 0) begin q = sa / sb; r = sa % sb; res = {r[31:0], q[31:0]}; end
      end
      3'd3: begin
        cyc = DC;
        if (b != 0) begin uq = ua / ub; ur = ua % ub; res = {ur[31:0], uq[31:0]}; end
      end
      3'd4: res = {a, lo};
      3'd5: res = {hi, a};
`ifdef MDU_MADD_EN
      3'd6: begin res = {hi, lo} + sa * sb; cyc = MC; end
      3'd7: begin res = {hi, lo} - sa * sb; cyc = MC; end
`endif
      default: ;
    endcase
  endfunction

  // Issue one op, flood the busy window with ignored starts, then check the commit.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [63:0] exp;
    int          cyc, busy_cnt;
    ref_eval(o, a, b, m_hi, m_lo, exp, cyc);
    start = 1'b1; op = o; A = a; B = b;
    @(posedge clk); #1;
    busy_cnt = 0;
    while (Busy && busy_cnt < 64) begin
      busy_cnt++;
      chk({tag, "_hold"}, {HI, LO}, {m_hi, m_lo});
      start = 1'($urandom_range(0, 1));
      op = 3'($urandom_range(0, 7));
      A = $urandom; B = $urandom;
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk({tag, "_busy"}, 64'(busy_cnt), 64'(cyc));
    chk({tag, "_hilo"}, {HI, LO}, exp);
    m_hi = exp[63:32];
    m_lo = exp[31:0];
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b0; op = 3'd0; A = '0; B = '0;
    m_hi = '0; m_lo = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hi", 64'(HI), 64'h0);
    chk("rst_lo", 64'(LO), 64'h0);
    chk("rst_busy", 64'(Busy), 64'h0);
    @(negedge clk) reset = 1'b1;

    // First edge after reset release accepts mthi
    issue(3'd4, 32'h1234, 32'h0, "mthi_first");
    chk("mthi_first_const", 64'(HI), 64'h1234);

    issue(3'd2, 32'd55, 32'd0, "div0");
    chk("div0_hi_const", 64'(HI), 64'h1234);

    issue(3'd0, 32'hFFFFFFFE, 32'd3, "mult");
    chk("mult_const", {HI, LO}, 64'hFFFFFFFF_FFFFFFFA);
    issue(3'd1, 32'hFFFFFFFE, 32'd3, "multu");
    chk("multu_const", {HI, LO}, 64'h00000002_FFFFFFFA);
    issue(3'd2, 32'hFFFFFFF9, 32'd2, "div");
    chk("div_const", {HI, LO}, 64'hFFFFFFFF_FFFFFFFD);
    issue(3'd3, 32'd7, 32'd2, "divu");
    chk("divu_const", {HI, LO}, 64'h00000001_00000003);
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
    chk("div_ovf_const", {HI, LO}, 64'h00000000_80000000);
    issue(3'd0, 32'd2, 32'd3, "mult23");
    chk("mult23_lo", 64'(LO), 64'd6);
    issue(3'd5, 32'hAA, 32'h0, "mtlo");
    chk("mtlo_const", 64'(LO), 64'hAA);
    issue(3'd6, 32'd9, 32'd9, "op6");
    issue(3'd7, 32'd9, 32'd9, "op7");

`ifdef MDU_MADD_EN
    issue(3'd4, 32'h0, 32'h0, "madd_pre_hi");
    issue(3'd5, 32'hFFFFFFFF, 32'h0, "madd_pre_lo");
    issue(3'd6, 32'd2, 32'd3, "madd");
    chk("madd_const", {HI, LO}, 64'h00000001_00000005);
`endif

    for (int i = 0; i < 40; i++)
      issue(3'($urandom_range(0, 7)), pick_val(), pick_val(), "rnd");

    // Reset mid-div aborts with no later commit
    issue(3'd4, 32'hDEAD, 32'h0, "pre_rst_hi");
    issue(3'd5, 32'hBEEF, 32'h0, "pre_rst_lo");
    start = 1'b1; op = 3'd2; A = 32'd100; B = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    chk("rst_div_busy", 64'(Busy), 64'h1);
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_hi", 64'(HI), 64'h0);
    chk("abort_lo", 64'(LO), 64'h0);
    chk("abort_busy", 64'(Busy), 64'h0);
    m_hi = '0; m_lo = '0;
    @(negedge clk) reset = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    chk("no_commit_hilo", {HI, LO}, 64'h0);
    chk("no_commit_busy", 64'(Busy), 64'h0);
    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mdu_hilo.md
MDU_HILO -- requirements
Module: mdu_hilo

Interface
REQ-001 Parameter MULT_CYCLES, default 5, SHALL set the number of Busy cycles for mult/multu.
REQ-002 Parameter DIV_CYCLES, default 10, SHALL set the number of Busy cycles for div/divu.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 start  input  1  SHALL request an operation (E-stage startE).
REQ-006 op  input  3  SHALL select the operation: 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 110/111 reserved.
REQ-007 A  input  32  SHALL be the forwarded rs operand.
REQ-008 B  input  32  SHALL be the forwarded rt operand.
REQ-009 HI  output  32  SHALL present the architectural HI register (mfhi source).
REQ-010 LO  output  32  SHALL present the architectural LO register (mflo source).
REQ-011 Busy  output  1  SHALL be high while a mult/div is in flight (BusyE to the hazard unit).

Function
REQ-012 FSM states SHALL be IDLE and RUN; a down-counter and a 64-bit pending-result register SHALL be kept.
REQ-013 In IDLE, start=1 with op mult/multu/div/divu SHALL latch the result into pending, load the counter with the op's cycle count, and enter RUN.
REQ-014 Busy SHALL be registered: with start sampled at edge t, Busy SHALL be high from edge t through edge t+N, where N is the op's cycle count.
REQ-015 HI/LO SHALL keep their old values during RUN; at edge t+N, pending SHALL be committed to {HI,LO} and the FSM SHALL return to IDLE with Busy=0.
REQ-016 mult: {HI,LO} SHALL equal the signed 64-bit A*B; multu SHALL use the unsigned product.
REQ-017 div: LO SHALL be the quotient truncated toward zero; HI SHALL be the remainder with the dividend's sign; divu SHALL be unsigned.
REQ-018 Signed 0x80000000 / 0xFFFFFFFF SHALL yield LO=0x80000000, HI=0.
REQ-019 Division by zero SHALL still run DIV_CYCLES with Busy high, and SHALL leave HI and LO unchanged.
REQ-020 mthi/mtlo in IDLE SHALL write A to HI/LO at the same edge, with no Busy assertion.
REQ-021 Any start while in RUN (Busy=1) SHALL be ignored, including mthi/mtlo.
REQ-022 start with a reserved op SHALL be ignored.
REQ-023 A start in the same cycle as the commit edge SHALL be ignored; a new op SHALL be accepted only once Busy=0.

Reset
REQ-024 Asserting reset (low) SHALL asynchronously force HI=0, LO=0, Busy=0, FSM=IDLE, counter=0 and pending=0, aborting any in-flight op without commit.
REQ-025 The first start SHALL be accepted at the first rising edge after reset deasserts.

Configuration
REQ-026 With macro MDU_MADD_EN defined, op 110 (madd) SHALL add the signed product to {HI,LO}, and op 111 (msub) SHALL subtract it, both modulo 2^64 with MULT_CYCLES latency.
REQ-027 Without MDU_MADD_EN, ops 110/111 SHALL remain reserved and ignored.

Structure
REQ-028 The op encodings, the FSM state encoding and the cycle-count defaults SHALL live in shared package mdu_pkg, which Decode also uses.
REQ-029 No sub-module SHALL be instantiated; the arithmetic is combinational at issue and the latency is modelled by the counter.

Verification
REQ-030 mult with A=0xFFFFFFFE, B=3 -> Busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; multu with the same operands -> HI=2, LO=0xFFFFFFFA.
REQ-031 div with A=-7, B=2 -> Busy high 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu with A=7, B=2 -> LO=3, HI=1.
REQ-032 div with B=0 after mthi 0x1234 -> Busy high 10 cycles, then HI=0x1234 and LO unchanged.
REQ-033 mtlo 0xAA during RUN of a mult with A=2, B=3 -> ignored; LO=6 after commit; mtlo 0xAA issued after Busy falls -> LO=0xAA on the next edge.
REQ-034 reset pulsed low mid-div -> HI=LO=0 and Busy=0 immediately, with no later commit.
REQ-035 With MDU_MADD_EN, madd A=2, B=3 with {HI,LO}=0x0000_0000_FFFF_FFFF -> HI=1, LO=5.
